// File: rtl/fifo_word_serializer.sv
// Drains a one-deep wide FIFO and streams each popped word out as CHUNK_WIDTH slices over valid/ready.
// Define SERIALIZER_MSB_FIRST_EN to send slices MSB-first; the default build sends them LSB-first.
module fifo_word_serializer #(
   parameter int DATA_WIDTH  = 986,
   parameter int CHUNK_WIDTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]  fifo_rdata_i,
   output logic                   fifo_rden_o,
   output logic                   chunk_valid_o,
   input  logic                   chunk_ready_i,
   output logic [CHUNK_WIDTH-1:0] chunk_data_o,
   output logic                   chunk_last_o,
   output logic                   busy_o,
   output logic [CNT_WIDTH-1:0]   words_done_o
);

   localparam int NUM_CHUNKS = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
   localparam int IDX_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHUNKS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state;
   logic [IDX_WIDTH-1:0]   idx;
   logic [PAD_WIDTH-1:0]   buffer;
   logic [PAD_WIDTH-1:0]   buffer_next;
   logic [PAD_WIDTH-1:0]   padded;
   logic [CHUNK_WIDTH-1:0] first_slice;
   logic [CHUNK_WIDTH-1:0] next_slice;
   logic                   xfer;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      padded                   = '0;
      padded[DATA_WIDTH-1:0]   = fifo_rdata_i;
   end

`ifdef SERIALIZER_MSB_FIRST_EN
   assign buffer_next = buffer << CHUNK_WIDTH;
   assign first_slice = padded[PAD_WIDTH-1 -: CHUNK_WIDTH];
   assign next_slice  = buffer_next[PAD_WIDTH-1 -: CHUNK_WIDTH];
`else
   assign buffer_next = buffer >> CHUNK_WIDTH;
   assign first_slice = padded[CHUNK_WIDTH-1:0];
   assign next_slice  = buffer_next[CHUNK_WIDTH-1:0];
`endif

   // The pop is gated by reset so a reset never disturbs the FIFO contents.
   assign fifo_rden_o = (state == IDLE) && !fifo_empty_i && !reset;
   assign xfer        = chunk_valid_o && chunk_ready_i;

   // NOTE: sequential state uses non-blocking assignments only; the wide buffer is cleared on reset too.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         buffer        <= '0;
         chunk_valid_o <= 1'b0;
         chunk_data_o  <= '0;
         chunk_last_o  <= 1'b0;
         busy_o        <= 1'b0;
         words_done_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_rden_o) begin
                  buffer        <= padded;
                  idx           <= '0;
                  chunk_data_o  <= first_slice;
                  chunk_last_o  <= (NUM_CHUNKS == 1);
                  chunk_valid_o <= 1'b1;
                  busy_o        <= 1'b1;
                  state         <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  buffer       <= buffer_next;
                  chunk_data_o <= next_slice;
                  if (idx == LAST_IDX) begin
                     state         <= IDLE;
                     chunk_valid_o <= 1'b0;
                     chunk_last_o  <= 1'b0;
                     busy_o        <= 1'b0;
                     words_done_o  <= words_done_o + CNT_WIDTH'(1);
                  end else begin
                     idx          <= idx + IDX_WIDTH'(1);
                     chunk_last_o <= ((idx + IDX_WIDTH'(1)) == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
